// File: rtl/usb_rx_pkg.sv
// usb_rx_pkg: shared RX packet codes, controller state encoding and default sizes.
package usb_rx_pkg;
    localparam logic [2:0] PKT_NONE = 3'd0;
    localparam logic [2:0] PKT_OUT  = 3'd1;
    localparam logic [2:0] PKT_IN   = 3'd2;
    localparam logic [2:0] PKT_DATA = 3'd3;
    localparam logic [2:0] PKT_ACK  = 3'd4;
    localparam logic [2:0] PKT_NAK  = 3'd5;
    localparam logic [2:0] PKT_ERR  = 3'd6;
    localparam logic [2:0] PKT_EOP  = 3'd7;
    typedef enum logic [2:0] {S_IDLE, S_WAIT_DATA, S_RCV, S_FLUSH, S_REPORT} rx_state_e;
    localparam int MAX_BYTES_DEF   = 64;
    localparam int BUF_DEPTH_DEF   = 64;
    localparam int TIMEOUT_CYC_DEF = 816;
endpackage

// File: rtl/usb_turnaround_timer.sv
// usb_turnaround_timer: clearable enabled counter flagging TIMEOUT_CYC-1 elapsed cycles.
// Ports: clk_i, n_rst_i (async active-low), clr_i (sync clear, wins over en_i),
//        en_i (count enable), tc_o (count has reached TIMEOUT_CYC-1).
module usb_turnaround_timer #(
    parameter int TIMEOUT_CYC = 816
) (
    input  logic clk_i,
    input  logic n_rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);
    localparam int W = $clog2(TIMEOUT_CYC) + 1;
    logic [W-1:0] cnt_q;
    assign tc_o = cnt_q == W'(TIMEOUT_CYC - 1);
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) cnt_q <= '0;
        else if (clr_i) cnt_q <= '0;
        else if (en_i && !tc_o) cnt_q <= cnt_q + 1'b1;
    end
endmodule

// File: rtl/usb_rx_pkt_ctrl.sv
// usb_rx_pkt_ctrl: sequences RX packets (token, DATA, EOP) into the endpoint data buffer.
// Ports: clk_i, n_rst_i (async active-low); rx_packet_i status code, rx_packet_data_i byte,
//        store_rx_packet_data_i byte strobe, buffer_occupancy_i fill level;
//        buffer_wen_o/buffer_wdata_o registered byte write, buffer_flush_o one-cycle clear;
//        rx_transfer_active_o, rx_data_ready_o/rx_error_o report pulses,
//        rx_pkt_type_o last accepted code, rx_byte_count_o accepted payload bytes.
module usb_rx_pkt_ctrl
    import usb_rx_pkg::*;
#(
    parameter int MAX_BYTES   = MAX_BYTES_DEF,
    parameter int BUF_DEPTH   = BUF_DEPTH_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic       clk_i,
    input  logic       n_rst_i,
    input  logic [2:0] rx_packet_i,
    input  logic [7:0] rx_packet_data_i,
    input  logic       store_rx_packet_data_i,
    input  logic [6:0] buffer_occupancy_i,
    output logic       buffer_wen_o,
    output logic [7:0] buffer_wdata_o,
    output logic       buffer_flush_o,
    output logic       rx_transfer_active_o,
    output logic       rx_data_ready_o,
    output logic       rx_error_o,
    output logic [2:0] rx_pkt_type_o,
    output logic [6:0] rx_byte_count_o
);
    rx_state_e  state_q, state_d;
    logic [2:0] prev_q, type_q, type_d;
    logic [7:0] wdata_q, wdata_d;
    logic [6:0] cnt_q, cnt_d;
    logic       err_q, err_d, wen_q, wen_d;
    logic       evt, tc, ovf;
    // A code is only an event on the cycle it changes, so a held code fires once.
    assign evt = rx_packet_i != prev_q;
    assign ovf = cnt_q == 7'(MAX_BYTES) || buffer_occupancy_i == 7'(BUF_DEPTH);
    usb_turnaround_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
        .clk_i   (clk_i),
        .n_rst_i (n_rst_i),
        .clr_i   (state_q != S_WAIT_DATA),
        .en_i    (state_q == S_WAIT_DATA),
        .tc_o    (tc)
    );
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        wen_d   = 1'b0;
        wdata_d = wdata_q;
        type_d  = type_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                err_d = 1'b0;
                if (evt && rx_packet_i == PKT_OUT) begin
                    state_d = S_WAIT_DATA;
                    type_d  = PKT_OUT;
                end else if (evt && rx_packet_i inside {PKT_IN, PKT_ACK, PKT_NAK}) begin
                    type_d = rx_packet_i;
                end else if (evt && rx_packet_i == PKT_DATA) begin
                    state_d = S_REPORT;
                    err_d   = 1'b1;
                end
            end
            S_WAIT_DATA: begin
                if (evt && rx_packet_i == PKT_DATA) begin
                    state_d = S_RCV;
                    type_d  = PKT_DATA;
                    cnt_d   = '0;
                end else if (tc || (evt && rx_packet_i inside {PKT_ERR, PKT_EOP})) begin
                    state_d = S_REPORT;
                    err_d   = 1'b1;
                end
            end
            S_RCV: begin
                if (store_rx_packet_data_i && ovf) begin
                    state_d = S_FLUSH;
                    err_d   = 1'b1;
                end else begin
                    // A byte strobed alongside EOP is still written before the report.
                    if (store_rx_packet_data_i) begin
                        wen_d   = 1'b1;
                        wdata_d = rx_packet_data_i;
                        cnt_d   = cnt_q + 1'b1;
                    end
                    if (evt && rx_packet_i == PKT_ERR) begin
                        state_d = S_FLUSH;
                        err_d   = 1'b1;
                    end else if (evt && rx_packet_i == PKT_EOP) begin
                        state_d = S_REPORT;
                    end
                end
            end
            S_FLUSH: state_d = S_REPORT;
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            state_q <= S_IDLE;
            prev_q  <= PKT_NONE;
            type_q  <= PKT_NONE;
            wdata_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            wen_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= rx_packet_i;
            type_q  <= type_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            wen_q   <= wen_d;
        end
    end
    assign buffer_wen_o         = wen_q;
    assign buffer_wdata_o       = wdata_q;
    assign buffer_flush_o       = state_q == S_FLUSH;
    assign rx_transfer_active_o = state_q inside {S_WAIT_DATA, S_RCV, S_FLUSH};
    assign rx_data_ready_o      = state_q == S_REPORT && !err_q;
    assign rx_error_o           = state_q == S_REPORT && err_q;
    assign rx_pkt_type_o        = type_q;
    assign rx_byte_count_o      = cnt_q;
endmodule

// File: tb/tb_usb_rx_pkt_ctrl.sv
// tb_usb_rx_pkt_ctrl: directed and randomized checks of usb_rx_pkt_ctrl against a behavioural model.
module tb_usb_rx_pkt_ctrl;
    import usb_rx_pkg::*;
    localparam int MAXB = 64, DEPTH = 64, TMO = 816;
    localparam int P_IDLE = 0, P_WAIT = 1, P_RCV = 2, P_FLUSH = 3, P_REPORT = 4;
    logic       clk = 1'b0, n_rst = 1'b0, stb = 1'b0;
    logic [2:0] pkt = PKT_NONE;
    logic [7:0] pdata = '0;
    logic [6:0] occ = '0;
    logic       wen, flush, active, ready, err;
    logic [7:0] wdata;
    logic [2:0] ptype;
    logic [6:0] bcnt;
    int checks = 0, errors = 0;
    int ph = P_IDLE, m_cnt = 0, m_since = 0, cyc = 0;
    logic [2:0] m_last = PKT_NONE, m_type = PKT_NONE;
    logic [7:0] m_wd = '0;
    bit m_bad = 0, m_wen = 0;
    int n_wen = 0, n_flush = 0, n_ready = 0, n_err = 0, err_cyc = -1;
    always #5 clk = ~clk;
    usb_rx_pkt_ctrl dut (
        .clk_i(clk), .n_rst_i(n_rst), .rx_packet_i(pkt), .rx_packet_data_i(pdata),
        .store_rx_packet_data_i(stb), .buffer_occupancy_i(occ), .buffer_wen_o(wen),
        .buffer_wdata_o(wdata), .buffer_flush_o(flush), .rx_transfer_active_o(active),
        .rx_data_ready_o(ready), .rx_error_o(err), .rx_pkt_type_o(ptype), .rx_byte_count_o(bcnt)
    );
    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic model_reset();
        ph = P_IDLE; m_cnt = 0; m_since = 0; m_last = PKT_NONE; m_type = PKT_NONE;
        m_bad = 0; m_wen = 0;
    endtask
    // One clock of the packet rules, applied to the inputs the DUT just sampled.
    task automatic model_step();
        bit ev, over;
        ev = pkt != m_last;
        m_last = pkt;
        m_wen = 0;
        case (ph)
            P_IDLE: begin
                m_bad = 0;
                if (ev && pkt == PKT_OUT) begin ph = P_WAIT; m_type = pkt; m_since = 0; end
                else if (ev && (pkt == PKT_IN || pkt == PKT_ACK || pkt == PKT_NAK)) m_type = pkt;
                else if (ev && pkt == PKT_DATA) begin ph = P_REPORT; m_bad = 1; end
            end
            P_WAIT: begin
                m_since++;
                if (ev && pkt == PKT_DATA) begin ph = P_RCV; m_type = PKT_DATA; m_cnt = 0; end
                else if (m_since == TMO || (ev && (pkt == PKT_ERR || pkt == PKT_EOP))) begin
                    ph = P_REPORT; m_bad = 1;
                end
            end
            P_RCV: begin
                over = stb && (m_cnt >= MAXB || int'(occ) >= DEPTH);
                if (over) begin ph = P_FLUSH; m_bad = 1; end
                else begin
                    if (stb) begin m_wen = 1; m_wd = pdata; m_cnt++; end
                    if (ev && pkt == PKT_ERR) begin ph = P_FLUSH; m_bad = 1; end
                    else if (ev && pkt == PKT_EOP) ph = P_REPORT;
                end
            end
            P_FLUSH: ph = P_REPORT;
            default: ph = P_IDLE;
        endcase
    endtask
    task automatic compare();
        chk("wen", int'(wen), int'(m_wen));
        if (m_wen) chk("wdata", int'(wdata), int'(m_wd));
        chk("flush", int'(flush), int'(ph == P_FLUSH));
        chk("active", int'(active), int'(ph == P_WAIT || ph == P_RCV || ph == P_FLUSH));
        chk("ready", int'(ready), int'(ph == P_REPORT && !m_bad));
        chk("error", int'(err), int'(ph == P_REPORT && m_bad));
        chk("pkt_type", int'(ptype), int'(m_type));
        chk("byte_count", int'(bcnt), m_cnt);
        n_wen += int'(wen); n_flush += int'(flush); n_ready += int'(ready); n_err += int'(err);
        cyc++;
        if (err) err_cyc = cyc;
    endtask
    task automatic step(input logic [2:0] p, input bit s, input logic [7:0] d);
        pkt = p; stb = s; pdata = d;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask
    task automatic idle(input int n);
        repeat (n) step(PKT_NONE, 0, 8'h00);
    endtask
    task automatic token_data(input int gap);
        step(PKT_OUT, 0, 8'h00);
        repeat (gap) step(PKT_OUT, 0, 8'h00);
        step(PKT_DATA, 0, 8'h00);
    endtask
    logic [7:0] t1_bytes [4];
    int b_wen, b_flush, b_ready, b_err, t0;
    initial begin
        t1_bytes = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
        @(negedge clk); @(negedge clk);
        model_reset();
        compare();
        n_rst = 1'b1;
        idle(3);
        // Nominal 4-byte packet.
        b_wen = n_wen; b_ready = n_ready;
        token_data(20);
        for (int i = 0; i < 4; i++) step(PKT_DATA, 1, t1_bytes[i]);
        step(PKT_EOP, 0, 8'h00);
        chk("t1_ready", int'(ready), 1);
        chk("t1_active_fall", int'(active), 0);
        chk("t1_count", int'(bcnt), 4);
        idle(3);
        chk("t1_writes", n_wen - b_wen, 4);
        chk("t1_ready_pulses", n_ready - b_ready, 1);
        // Turnaround timeout.
        b_wen = n_wen; b_flush = n_flush; err_cyc = -1;
        step(PKT_OUT, 0, 8'h00);
        t0 = cyc;
        for (int i = 0; i < 1000 && err_cyc < 0; i++) step(PKT_OUT, 0, 8'h00);
        chk("t2_timeout_cycle", err_cyc - t0, TMO);
        chk("t2_no_write", n_wen - b_wen, 0);
        chk("t2_no_flush", n_flush - b_flush, 0);
        idle(3);
        // Payload overflow at 65 bytes.
        b_wen = n_wen; b_flush = n_flush; b_err = n_err;
        token_data(5);
        for (int i = 0; i < 65; i++) step(PKT_DATA, 1, 8'($urandom));
        idle(4);
        chk("t3_writes", n_wen - b_wen, 64);
        chk("t3_flush", n_flush - b_flush, 1);
        chk("t3_error", n_err - b_err, 1);
        chk("t3_count", int'(bcnt), 64);
        // ERR mid-packet.
        b_wen = n_wen; b_flush = n_flush; b_err = n_err;
        token_data(2);
        for (int i = 0; i < 3; i++) step(PKT_DATA, 1, 8'($urandom));
        step(PKT_ERR, 0, 8'h00);
        idle(4);
        chk("t4_writes", n_wen - b_wen, 3);
        chk("t4_flush", n_flush - b_flush, 1);
        chk("t4_error", n_err - b_err, 1);
        chk("t4_type", int'(ptype), int'(PKT_DATA));
        // Buffer already full.
        b_wen = n_wen; b_flush = n_flush; b_err = n_err;
        occ = 7'd64;
        token_data(1);
        step(PKT_DATA, 1, 8'h77);
        idle(4);
        occ = 7'd0;
        chk("t5_writes", n_wen - b_wen, 0);
        chk("t5_flush", n_flush - b_flush, 1);
        chk("t5_error", n_err - b_err, 1);
        // Reset mid-packet, then unsolicited DATA.
        token_data(1);
        step(PKT_DATA, 1, 8'h11);
        step(PKT_DATA, 1, 8'h22);
        n_rst = 1'b0; stb = 1'b0;
        #1;
        model_reset();
        compare();
        @(posedge clk); @(negedge clk);
        n_rst = 1'b1;
        b_err = n_err; b_flush = n_flush;
        step(PKT_DATA, 0, 8'h00);
        chk("t6_unsolicited", int'(err), 1);
        idle(3);
        chk("t6_error_pulses", n_err - b_err, 1);
        chk("t6_no_flush", n_flush - b_flush, 0);
        // Randomized episodes.
        for (int e = 0; e < 150; e++) begin
            int gap, nb, r;
            idle(1 + $urandom_range(0, 2));
            r = $urandom_range(0, 9);
            if (r == 0) step(3'($urandom_range(2, 5)), 1'($urandom), 8'($urandom));
            if (r == 1) step(PKT_DATA, 0, 8'h00);
            occ = ($urandom_range(0, 7) == 0) ? 7'd64 : 7'($urandom_range(0, 63));
            gap = ($urandom_range(0, 24) == 0) ? 820 : $urandom_range(0, 30);
            step(PKT_OUT, 0, 8'h00);
            for (int i = 0; i < gap; i++)
                step(($urandom_range(0, 9) == 0) ? 3'($urandom) : PKT_OUT, 1'($urandom), 8'($urandom));
            step(PKT_DATA, 0, 8'h00);
            nb = $urandom_range(0, 70);
            for (int i = 0; i < nb; i++) begin
                if ($urandom_range(0, 3) == 0) step(PKT_DATA, 0, 8'h00);
                step(PKT_DATA, 1, 8'($urandom));
                if ($urandom_range(0, 15) == 0) occ = 7'd64;
            end
            r = $urandom_range(0, 9);
            step(r < 7 ? PKT_EOP : (r < 9 ? PKT_ERR : 3'($urandom)), 1'($urandom), 8'($urandom));
            idle(3);
            occ = 7'd0;
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/usb_rx_pkt_ctrl.md
Name: usb_rx_pkt_ctrl

Overview:
Packet-level controller sequencing the USB RX datapath into the endpoint data buffer. Consumes per-packet status codes and stored payload bytes from the RX module and gates byte writes into the shared data buffer. Enforces the token→DATA ordering with a turnaround timeout, caps payload length, and flushes partial data on error. Reports packet type, byte count and completion or error to the protocol controller and AHB slave.

Parameters:
MAX_BYTES, 64, maximum payload bytes per DATA packet.
BUF_DEPTH, 64, data buffer capacity in bytes.
TIMEOUT_CYC, 816, clock cycles allowed between an OUT token and the DATA packet start (≈16 bit times at 51 clk/bit).

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
rx_packet  in  3  RX status code (see package)
rx_packet_data  in  8  received payload byte
store_rx_packet_data  in  1  one-cycle strobe, rx_packet_data valid
buffer_occupancy  in  7  current data buffer fill level, 0..BUF_DEPTH
buffer_wen  out  1  write strobe to data buffer
buffer_wdata  out  8  byte to data buffer
buffer_flush  out  1  one-cycle clear of data buffer
rx_transfer_active  out  1  high from token accept to final report
rx_data_ready  out  1  one-cycle pulse, valid DATA packet fully buffered
rx_error  out  1  one-cycle pulse, packet rejected
rx_pkt_type  out  3  last accepted packet code, held until next
rx_byte_count  out  7  payload bytes accepted in current or last packet

Behaviour:
- Reset: all outputs 0; state IDLE; timer and byte counter cleared.
- Codes: NONE=0, OUT=1, IN=2, DATA=3, ACK=4, NAK=5, ERR=6, EOP=7. Sampled every cycle; a code counts as an event only on the cycle it differs from the previous sampled value.
- IDLE:
  - OUT event → WAIT_DATA. Load rx_pkt_type, clear the timer, assert rx_transfer_active.
  - IN, ACK or NAK event → update rx_pkt_type only and stay in IDLE.
  - DATA event → flag error and go to REPORT (unsolicited data).
  - Strobes in IDLE are ignored. buffer_wen stays 0.
- WAIT_DATA:
  - Timer increments each cycle.
  - DATA event → RCV. Clear rx_byte_count.
  - Timer reaching TIMEOUT_CYC-1, or an ERR or EOP event → flag error and go to REPORT.
- RCV:
  - Each store strobe: buffer_wen=1 and buffer_wdata=rx_packet_data on the same cycle (combinational pass-through with a registered enable is not allowed; both outputs are registered, so latency is 1 cycle from the strobe). rx_byte_count increments.
  - Overflow: a strobe arriving when rx_byte_count==MAX_BYTES, or when buffer_occupancy==BUF_DEPTH, suppresses the write, flags error and goes to FLUSH.
  - EOP event → REPORT with success.
  - ERR event → FLUSH.
  - A strobe and an EOP event on the same cycle: the byte is written first, then the state moves to REPORT.
- FLUSH: buffer_flush=1 for exactly one cycle, then REPORT with error.
- REPORT: pulse rx_data_ready (success) or rx_error (error) for one cycle. Deassert rx_transfer_active the same cycle. Return to IDLE.
- A zero-length DATA packet (EOP with count 0) is valid and pulses rx_data_ready.
- rx_byte_count saturates at MAX_BYTES and holds until the next DATA event.
- Reset mid-packet: immediate return to IDLE with no flush pulse. Buffer contents are the buffer's own reset responsibility.

Decomposition:
- Shared package usb_rx_pkg:
  - rx_packet code localparams (NONE..EOP).
  - State enum: IDLE, WAIT_DATA, RCV, FLUSH, REPORT.
  - Default MAX_BYTES and BUF_DEPTH constants.
- One natural sub-module, usb_turnaround_timer: a clearable counter with enable and terminal-count output, sized by TIMEOUT_CYC.

Test Plan:
- OUT event, then DATA within 100 cycles, 4 strobes with bytes A5,3C,FF,00, then EOP → 4 buffer_wen pulses with matching wdata; rx_byte_count=4; a single rx_data_ready pulse; rx_transfer_active falls on the same cycle.
- OUT event, then no DATA for 816 cycles → rx_error pulses at cycle 816 after the token; no buffer_wen; no flush.
- OUT, DATA, 65 strobes → 64 writes; 65th suppressed; buffer_flush one cycle; then rx_error; rx_byte_count=64.
- OUT, DATA, 3 strobes, ERR → 3 writes, then buffer_flush pulse, then rx_error; rx_pkt_type=DATA.
- buffer_occupancy held at 64, OUT, DATA, 1 strobe → no write; flush; rx_error.
- OUT, DATA, 2 strobes, n_rst low for 1 cycle → all outputs 0; IDLE; a following DATA event without a token → rx_error pulse.
